// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive path.
// CRC helpers exist only when USB_RX_CRC_CHECK_EN is defined.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC_RCV,
    ST_PID_RCV,
    ST_TOKEN_RCV,
    ST_DATA_RCV,
    ST_EOP_WAIT,
    ST_DONE,
    ST_ERR
  } rx_state_e;

  typedef enum logic [2:0] {
    PKT_NONE  = 3'd0,
    PKT_OUT   = 3'd1,
    PKT_IN    = 3'd2,
    PKT_DATA0 = 3'd3,
    PKT_DATA1 = 3'd4,
    PKT_ACK   = 3'd5,
    PKT_NAK   = 3'd6
  } rx_pkt_e;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  function automatic rx_pkt_e decodePid(input logic [7:0] pid);
    case (pid)
      PID_OUT:   return PKT_OUT;
      PID_IN:    return PKT_IN;
      PID_DATA0: return PKT_DATA0;
      PID_DATA1: return PKT_DATA1;
      PID_ACK:   return PKT_ACK;
      PID_NAK:   return PKT_NAK;
      default:   return PKT_NONE;
    endcase
  endfunction

`ifdef USB_RX_CRC_CHECK_EN
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_INIT      = 5'h1F;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;

  function automatic logic [15:0] crc16Step(input logic [15:0] crc, input logic din);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
  endfunction

  function automatic logic [4:0] crc5Step(input logic [4:0] crc, input logic din);
    return {crc[3:0], 1'b0} ^ ((crc[4] ^ din) ? CRC5_POLY : 5'h00);
  endfunction
`endif

endpackage

// File: rtl/usb_rx_byte_shifter.sv
// LSB-first deserialiser: 8-bit shift register, 3-bit bit counter and a
// byte_done flag on the strobe that completes bit 7.
module usb_rx_byte_shifter (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear_i,
  input  logic       shift_i,
  input  logic       bit_i,
  output logic [7:0] byte_o,
  output logic [2:0] bit_cnt_o,
  output logic       byte_done_o
);

  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_i) begin
      shift_d = {bit_i, shift_q[7:1]};
      cnt_d   = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // The completed byte is presented on the same strobe that finishes it.
  assign byte_o      = {bit_i, shift_q[7:1]};
  assign bit_cnt_o   = cnt_q;
  assign byte_done_o = shift_i & ~clear_i & (cnt_q == 3'd7);

endmodule

// File: rtl/usb_rx_fsm.sv
// USB full-speed packet receiver: framing checks, PID classification and
// payload push with CRC-byte holdback. Optional CRC checking: USB_RX_CRC_CHECK_EN.
module usb_rx_fsm #(
  parameter int MAX_PAYLOAD = 64,
  parameter int CNT_W       = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             d_edge,
  input  logic             shift_enable,
  input  logic             d_orig,
  input  logic             eop,
  output logic             rx_transfer_active,
  output logic [2:0]       rx_packet,
  output logic             rx_data_ready,
  output logic             rx_error,
  output logic             store_rx_packet_data,
  output logic [7:0]       rx_packet_data,
  output logic [CNT_W-1:0] rx_data_count
);

  import usb_rx_pkg::*;

  rx_state_e        state_q, state_d;
  rx_pkt_e          rx_packet_q, rx_packet_d, pkt;
  logic             rx_error_q, rx_error_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       h0_q, h0_d, h1_q, h1_d;
  logic [1:0]       held_q, held_d;
  logic             tok_q, tok_d;
  logic             eop_seen_q, eop_seen_d;
  logic             err_eop_q, err_eop_d;
  logic             store_q, store_d;
  logic [7:0]       data_q, data_d;

  logic       shift_bit, eop_strobe, eop_bad, go_err, crc_ok, clear_shifter;
  logic [7:0] rx_byte;
  logic [2:0] bit_cnt;
  logic       byte_done;

  // EOP strobes carry no data bit, so they never advance the bit counter.
  assign shift_bit     = shift_enable & ~eop;
  assign eop_strobe    = shift_enable & eop;
  assign clear_shifter = (state_q == ST_IDLE) & d_edge;

  usb_rx_byte_shifter u_shifter (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear_i     (clear_shifter),
    .shift_i     (shift_bit),
    .bit_i       (d_orig),
    .byte_o      (rx_byte),
    .bit_cnt_o   (bit_cnt),
    .byte_done_o (byte_done)
  );

  assign eop_bad = eop_strobe & (bit_cnt != 3'd0) &
                   (state_q != ST_IDLE) & (state_q != ST_DONE) & (state_q != ST_ERR);

`ifdef USB_RX_CRC_CHECK_EN
  logic [15:0] crc16_q, crc16_d;
  logic [4:0]  crc5_q, crc5_d;

  always_comb begin
    crc16_d = crc16_q;
    crc5_d  = crc5_q;
    if (state_q == ST_PID_RCV) begin
      crc16_d = CRC16_INIT;
      crc5_d  = CRC5_INIT;
    end else if (shift_bit && state_q == ST_DATA_RCV) begin
      crc16_d = crc16Step(crc16_q, d_orig);
    end else if (shift_bit && state_q == ST_TOKEN_RCV) begin
      crc5_d = crc5Step(crc5_q, d_orig);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc16_q <= '0;
      crc5_q  <= '0;
    end else begin
      crc16_q <= crc16_d;
      crc5_q  <= crc5_d;
    end
  end

  always_comb begin
    case (rx_packet_q)
      PKT_DATA0, PKT_DATA1: crc_ok = (crc16_q == CRC16_RESIDUAL);
      PKT_OUT, PKT_IN:      crc_ok = (crc5_q == CRC5_RESIDUAL);
      default:              crc_ok = 1'b1;
    endcase
  end
`else
  assign crc_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    rx_packet_d = rx_packet_q;
    rx_error_d  = rx_error_q;
    count_d     = count_q;
    h0_d        = h0_q;
    h1_d        = h1_q;
    held_d      = held_q;
    tok_d       = tok_q;
    eop_seen_d  = eop_seen_q;
    err_eop_d   = err_eop_q;
    store_d     = 1'b0;
    data_d      = data_q;
    pkt         = decodePid(rx_byte);
    go_err      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (d_edge) begin
          state_d     = ST_SYNC_RCV;
          rx_error_d  = 1'b0;
          rx_packet_d = PKT_NONE;
          count_d     = '0;
          held_d      = '0;
        end
      end
      ST_SYNC_RCV: begin
        if (eop_strobe) go_err = 1'b1;
        else if (byte_done) begin
          if (rx_byte == SYNC_BYTE) state_d = ST_PID_RCV;
          else go_err = 1'b1;
        end
      end
      ST_PID_RCV: begin
        if (eop_strobe) go_err = 1'b1;
        else if (byte_done) begin
          if ((rx_byte[3:0] != ~rx_byte[7:4]) || (pkt == PKT_NONE)) go_err = 1'b1;
          else begin
            rx_packet_d = pkt;
            tok_d       = 1'b0;
            eop_seen_d  = 1'b0;
            case (pkt)
              PKT_ACK, PKT_NAK: state_d = ST_EOP_WAIT;
              PKT_OUT, PKT_IN:  state_d = ST_TOKEN_RCV;
              default:          state_d = ST_DATA_RCV;
            endcase
          end
        end
      end
      ST_TOKEN_RCV: begin
        if (eop_strobe) go_err = 1'b1;
        else if (byte_done) begin
          if (tok_q) state_d = ST_EOP_WAIT;
          else tok_d = 1'b1;
        end
      end
      ST_DATA_RCV: begin
        // h1 is the older held byte; the last two bytes are the CRC and never leave.
        if (eop_strobe) begin
          if (held_q != 2'd2) go_err = 1'b1;
          else begin
            state_d    = ST_EOP_WAIT;
            eop_seen_d = 1'b1;
          end
        end else if (byte_done) begin
          if (held_q == 2'd2) begin
            if (count_q == CNT_W'(MAX_PAYLOAD)) go_err = 1'b1;
            else begin
              store_d = 1'b1;
              data_d  = h1_q;
              count_d = count_q + CNT_W'(1);
              h1_d    = h0_q;
              h0_d    = rx_byte;
            end
          end else begin
            h1_d   = h0_q;
            h0_d   = rx_byte;
            held_d = held_q + 2'd1;
          end
        end
      end
      ST_EOP_WAIT: begin
        if (shift_enable) begin
          if (!eop) go_err = 1'b1;
          else if (!eop_seen_q) eop_seen_d = 1'b1;
          else if (!crc_ok) go_err = 1'b1;
          else state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR: begin
        if (shift_enable) begin
          if (eop) err_eop_d = 1'b1;
          else if (err_eop_q) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (eop_bad) go_err = 1'b1;

    // An eop that causes the error already counts toward leaving ERR.
    if (go_err) begin
      state_d     = ST_ERR;
      rx_packet_d = PKT_NONE;
      rx_error_d  = 1'b1;
      err_eop_d   = eop_strobe;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      rx_packet_q <= PKT_NONE;
      rx_error_q  <= 1'b0;
      count_q     <= '0;
      h0_q        <= '0;
      h1_q        <= '0;
      held_q      <= '0;
      tok_q       <= 1'b0;
      eop_seen_q  <= 1'b0;
      err_eop_q   <= 1'b0;
      store_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      rx_packet_q <= rx_packet_d;
      rx_error_q  <= rx_error_d;
      count_q     <= count_d;
      h0_q        <= h0_d;
      h1_q        <= h1_d;
      held_q      <= held_d;
      tok_q       <= tok_d;
      eop_seen_q  <= eop_seen_d;
      err_eop_q   <= err_eop_d;
      store_q     <= store_d;
      data_q      <= data_d;
    end
  end

  assign rx_transfer_active   = (state_q != ST_IDLE);
  assign rx_data_ready        = (state_q == ST_DONE);
  assign rx_packet            = rx_packet_q;
  assign rx_error             = rx_error_q;
  assign store_rx_packet_data = store_q;
  assign rx_packet_data       = data_q;
  assign rx_data_count        = count_q;

endmodule

// File: tb/tb_usb_rx_fsm.sv
// Self-checking bench for usb_rx_fsm: payload bytes are queued as they are
// sent and popped when the store strobe fires.
module tb_usb_rx_fsm;

  localparam int MAX = 64;

  logic       clk, n_rst, d_edge, shift_enable, d_orig, eop;
  logic       rx_transfer_active, rx_data_ready, rx_error, store_rx_packet_data;
  logic [2:0] rx_packet;
  logic [7:0] rx_packet_data;
  logic [6:0] rx_data_count;

  int numChecks  = 0;
  int numBad     = 0;
  int readyCount = 0;
  logic [7:0] expQ[$];
  logic [7:0] payload[$];

  usb_rx_fsm dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .d_edge               (d_edge),
    .shift_enable         (shift_enable),
    .d_orig               (d_orig),
    .eop                  (eop),
    .rx_transfer_active   (rx_transfer_active),
    .rx_packet            (rx_packet),
    .rx_data_ready        (rx_data_ready),
    .rx_error             (rx_error),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .rx_data_count        (rx_data_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numBad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Scoreboard consumer and ready-pulse counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (n_rst && rx_data_ready) readyCount++;
    if (n_rst && store_rx_packet_data) begin
      if (expQ.size() == 0) checkOutput("store_unexpected", {24'h0, rx_packet_data}, 32'h100);
      else checkOutput("store_data", {24'h0, rx_packet_data}, {24'h0, expQ.pop_front()});
    end
  end

  task automatic strobe(input logic b, input logic e);
    @(posedge clk); #1;
    shift_enable = 1'b1; d_orig = b; eop = e;
    @(posedge clk); #1;
    shift_enable = 1'b0; d_orig = 1'b0; eop = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) strobe(v[i], 1'b0);
  endtask

  task automatic pulseEdge();
    @(posedge clk); #1 d_edge = 1'b1;
    @(posedge clk); #1 d_edge = 1'b0;
  endtask

  task automatic addCrc16();
    logic [15:0] c, inv;
    logic [7:0]  b0, b1;
    c = 16'hFFFF;
    foreach (payload[k])
      for (int i = 0; i < 8; i++)
        c = {c[14:0], 1'b0} ^ ((c[15] ^ payload[k][i]) ? 16'h8005 : 16'h0000);
    inv = ~c;
    for (int i = 0; i < 8; i++) begin
      b0[i] = inv[15-i];
      b1[i] = inv[7-i];
    end
    payload.push_back(b0);
    payload.push_back(b1);
  endtask

  task automatic makeToken(input logic [6:0] addr, input logic [3:0] endp);
    logic [10:0] d;
    logic [4:0]  c;
    logic [15:0] bits;
    d = {endp, addr};
    c = 5'h1F;
    for (int i = 0; i < 11; i++) c = {c[3:0], 1'b0} ^ ((c[4] ^ d[i]) ? 5'h05 : 5'h00);
    bits[10:0] = d;
    for (int i = 0; i < 5; i++) bits[11+i] = ~c[4-i];
    payload = {bits[7:0], bits[15:8]};
  endtask

  // One full packet: SYNC, PID, payload bytes, two eop strobes and a J bit.
  task automatic applyStimulus(input logic [7:0] syncByte, input logic [7:0] pid,
                               input logic expReady, input logic expErr, input logic [2:0] expPkt);
    int   startReady, nStore, sz;
    logic isData;
    isData     = (syncByte == 8'h80) && (pid == 8'hC3 || pid == 8'h4B);
    startReady = readyCount;
    sz         = payload.size();
    nStore     = 0;
    if (isData && sz > 2) nStore = (sz - 2 > MAX) ? MAX : sz - 2;
    pulseEdge();
    sendByte(syncByte);
    sendByte(pid);
    for (int k = 0; k < sz; k++) begin
      if (isData && k < sz - 2 && k < MAX) expQ.push_back(payload[k]);
      sendByte(payload[k]);
      checkOutput("store_latency", {31'h0, store_rx_packet_data},
                  {31'h0, (isData && k >= 2 && k - 2 < MAX)});
    end
    strobe(1'b0, 1'b1);
    strobe(1'b0, 1'b1);
    checkOutput("ready_latency", {31'h0, rx_data_ready}, {31'h0, expReady});
    strobe(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("ready_count", readyCount - startReady, {31'h0, expReady});
    checkOutput("error", {31'h0, rx_error}, {31'h0, expErr});
    checkOutput("packet", {29'h0, rx_packet}, {29'h0, expPkt});
    checkOutput("active_end", {31'h0, rx_transfer_active}, 32'h0);
    checkOutput("count", {25'h0, rx_data_count}, nStore);
    checkOutput("store_drain", expQ.size(), 32'h0);
    expQ.delete();
  endtask

  initial begin
    int r0;
    n_rst = 1'b1; d_edge = 1'b0; shift_enable = 1'b0; d_orig = 1'b0; eop = 1'b0;
    #2 n_rst = 1'b0;
    #2;
    checkOutput("reset_outputs", {10'h0, rx_transfer_active, rx_packet, rx_data_ready, rx_error,
                store_rx_packet_data, rx_packet_data, rx_data_count}, 32'h0);
    #20 n_rst = 1'b1;
    repeat (2) @(posedge clk);

    payload.delete();                      applyStimulus(8'h80, 8'hD2, 1'b1, 1'b0, 3'd5);
    payload = {8'h11, 8'h22, 8'h33};       addCrc16(); applyStimulus(8'h80, 8'hC3, 1'b1, 1'b0, 3'd3);
    payload.delete();                      addCrc16(); applyStimulus(8'h80, 8'h4B, 1'b1, 1'b0, 3'd4);
    makeToken(7'h15, 4'h1);                applyStimulus(8'h80, 8'hE1, 1'b1, 1'b0, 3'd1);
    makeToken(7'h02, 4'h0);                applyStimulus(8'h80, 8'h69, 1'b1, 1'b0, 3'd2);
    payload.delete();                      applyStimulus(8'h80, 8'h5A, 1'b1, 1'b0, 3'd6);

    payload.delete();                      applyStimulus(8'h80, 8'hC4, 1'b0, 1'b1, 3'd0);
    pulseEdge();
    checkOutput("error_clear", {31'h0, rx_error}, 32'h0);
    checkOutput("active_start", {31'h0, rx_transfer_active}, 32'h1);
    strobe(1'b0, 1'b1); strobe(1'b0, 1'b1); strobe(1'b1, 1'b0);
    repeat (2) @(posedge clk);

    payload.delete();                      applyStimulus(8'h81, 8'hD2, 1'b0, 1'b1, 3'd0);
    payload = {8'h15};                     applyStimulus(8'h80, 8'hE1, 1'b0, 1'b1, 3'd0);

    payload.delete();
    for (int i = 0; i < MAX; i++) payload.push_back(8'(i * 3 + 1));
    addCrc16();                            applyStimulus(8'h80, 8'hC3, 1'b1, 1'b0, 3'd3);
    payload.delete();
    for (int i = 0; i < MAX + 1; i++) payload.push_back(8'(i * 5 + 2));
    addCrc16();                            applyStimulus(8'h80, 8'h4B, 1'b0, 1'b1, 3'd0);

    // eop in the middle of a payload byte
    r0 = readyCount;
    pulseEdge(); sendByte(8'h80); sendByte(8'hC3); sendByte(8'h11);
    strobe(1'b0, 1'b0); strobe(1'b1, 1'b0); strobe(1'b0, 1'b0);
    strobe(1'b0, 1'b1);
    checkOutput("eopmid_error", {31'h0, rx_error}, 32'h1);
    checkOutput("eopmid_packet", {29'h0, rx_packet}, 32'h0);
    strobe(1'b0, 1'b1); strobe(1'b1, 1'b0);
    repeat (2) @(posedge clk); #1;
    checkOutput("eopmid_idle", {31'h0, rx_transfer_active}, 32'h0);
    checkOutput("eopmid_ready", readyCount - r0, 32'h0);

    // asynchronous reset in the middle of a DATA payload
    r0 = readyCount;
    pulseEdge(); sendByte(8'h80); sendByte(8'hC3);
    expQ.push_back(8'hA1); expQ.push_back(8'hA2);
    sendByte(8'hA1); sendByte(8'hA2); sendByte(8'hA3); sendByte(8'hA4);
    strobe(1'b1, 1'b0); strobe(1'b0, 1'b0); strobe(1'b1, 1'b0);
    n_rst = 1'b0;
    #1;
    checkOutput("reset_mid", {10'h0, rx_transfer_active, rx_packet, rx_data_ready, rx_error,
                store_rx_packet_data, rx_packet_data, rx_data_count}, 32'h0);
    #20 n_rst = 1'b1;
    repeat (10) @(posedge clk); #1;
    checkOutput("reset_no_ready", readyCount - r0, 32'h0);
    checkOutput("reset_drain", expQ.size(), 32'h0);
    checkOutput("reset_idle", {31'h0, rx_transfer_active}, 32'h0);
    expQ.delete();

`ifdef USB_RX_CRC_CHECK_EN
    payload = {8'h01, 8'h02, 8'h03};       addCrc16(); applyStimulus(8'h80, 8'hC3, 1'b1, 1'b0, 3'd3);
    payload = {8'h01, 8'h02, 8'h03};       addCrc16();
    payload[1] = payload[1] ^ 8'h10;       applyStimulus(8'h80, 8'hC3, 1'b0, 1'b1, 3'd0);
`endif

    $display("test done: total=%0d bad=%0d", numChecks, numBad);
    $finish;
  end

endmodule

// File: doc/usb_rx_fsm.md
Name: usb_rx_fsm

Overview:
- USB full-speed packet receiver control; mirror of the endpoint transmit FSM.
- Consumes NRZI-decoded, unstuffed bits (one strobe per bit) from the line front-end, checks SYNC/PID/EOP framing, classifies packet type, strips the 2 CRC bytes from DATA payloads, and pushes payload bytes into the endpoint data buffer.
- Sits between the bit decoder/EOP detector and the data buffer; results go to the protocol controller.

Parameters:
- MAX_PAYLOAD, 64, maximum DATA payload bytes; one more is an error.
- CNT_W, 7, width of rx_data_count; must hold MAX_PAYLOAD.

Ports:
- clk  in  1  system clock
- n_rst  in  1  async active-low reset
- d_edge  in  1  one-cycle pulse: first line transition after idle
- shift_enable  in  1  one-cycle strobe per received bit
- d_orig  in  1  decoded bit, valid with shift_enable
- eop  in  1  SE0 present, sampled with shift_enable
- rx_transfer_active  out  1  packet reception in progress
- rx_packet  out  3  0 none, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK
- rx_data_ready  out  1  one-cycle pulse: good packet complete
- rx_error  out  1  framing/PID/length error, sticky
- store_rx_packet_data  out  1  one-cycle write strobe to data buffer
- rx_packet_data  out  8  payload byte, valid with the store strobe
- rx_data_count  out  CNT_W  payload bytes stored in the current packet

Behaviour:
- Reset: all outputs 0; state IDLE; shift register, bit counter and holdback regs cleared.
- Bits are shifted LSB-first into an 8-bit register on shift_enable; bit counter 0..7 wraps. byte_done is asserted on the strobe that completes bit 7.
- States and transitions:
  - IDLE: on d_edge, go to SYNC_RCV; rx_transfer_active=1; rx_error, rx_packet and rx_data_count cleared.
  - SYNC_RCV: on byte_done, go to PID_RCV if byte==8'h80, else ERR.
  - PID_RCV: on byte_done, require pid[3:0]==~pid[7:4] and a PID from the supported set, else ERR. Latch rx_packet. ACK/NAK go to EOP_WAIT; OUT/IN go to TOKEN_RCV; DATA0/DATA1 go to DATA_RCV.
  - TOKEN_RCV: requires exactly 2 bytes; the 2nd byte_done goes to EOP_WAIT. Token bytes are not stored.
  - DATA_RCV: two-byte holdback pipeline h0/h1. On each byte_done with 2 bytes already held, h1 is driven onto rx_packet_data with store_rx_packet_data=1 for one cycle, then the holdback shifts and rx_data_count increments. The count reaching MAX_PAYLOAD+1 goes to ERR. eop at bit count 0 goes to EOP_WAIT; fewer than 2 bytes held at that point goes to ERR.
  - EOP_WAIT: on each shift_enable, eop must be 1 for 2 consecutive strobes, then go to DONE. For non-DATA states, eop must also arrive at bit count 0.
  - DONE: rx_data_ready=1 for one cycle; go to IDLE; rx_transfer_active falls on exit.
  - ERR: rx_error=1 and rx_packet=0. Stay until a shift_enable with eop=0 follows an eop=1, then go to IDLE. rx_error holds until the next d_edge.
- Error conditions:
  - eop at a nonzero bit count in any state goes to ERR.
  - eop in SYNC_RCV/PID_RCV/TOKEN_RCV before the byte count is satisfied goes to ERR.
- d_edge outside IDLE is ignored.
- Latency: store strobe is 1 cycle after the byte_done strobe. rx_data_ready is 1 cycle after the 2nd eop strobe.
- Bytes already stored before an error remain counted; the controller discards them.
- Async reset mid-packet returns to IDLE immediately; no partial pulses after release.

Optional Feature:
- Macro: USB_RX_CRC_CHECK_EN.
- When defined:
  - CRC16 (poly 16'h8005, init 16'hFFFF, LSB-first per bit) runs over every DATA payload and CRC bit.
  - In EOP_WAIT completion, residual !=16'h800D goes to ERR instead of DONE.
  - Token CRC5 runs likewise (poly 5'h05, init 5'h1F, residual 5'h0C).
- When undefined: no CRC logic; CRC bytes are only stripped.

Decomposition:
- Package usb_rx_pkg:
  - state enum
  - rx_packet codes
  - PID constants: OUT 8'hE1, IN 8'h69, DATA0 8'hC3, DATA1 8'h4B, ACK 8'hD2, NAK 8'h5A
  - SYNC_BYTE 8'h80
  - CRC residual constants
- Sub-module: usb_rx_byte_shifter (shift register + 3-bit counter + byte_done).

Test Plan:
- ACK: SYNC 0x80, PID 0xD2, 2 eop strobes -> rx_packet=5, rx_data_ready 1 pulse, no store, rx_error=0.
- DATA0, payload 0x11,0x22,0x33 + CRC 2 bytes, EOP -> exactly 3 stores in order 0x11,0x22,0x33; rx_data_count=3; rx_packet=3; ready pulse.
- PID 0xC4 (check fails) -> rx_error=1, rx_packet=0, no ready; next d_edge clears rx_error.
- DATA1 with 65 payload bytes (MAX_PAYLOAD=64) -> 64 stores then ERR; no ready.
- eop at bit 3 of a DATA byte -> ERR. Reset asserted mid-DATA -> all outputs 0 immediately.
- USB_RX_CRC_CHECK_EN: correct CRC -> ready; one flipped payload bit -> rx_error, no ready.
